// File: rtl/main_core_arbiter.sv
// main_core_arbiter
//   Shares one main_core_serialCmd between two requesters (c0, c1). A requester
//   raises req, waits for gnt, then drives the core through a zero-latency,
//   gnt-gated passthrough. Arbitration is round-robin and only happens at
//   transaction boundaries (IDLE). A watchdog revokes a grant that has stalled
//   for TIMEOUT cycles and blocks that requester until it drops req.
//
// Ports
//   clk, rst                 clock / async active-low reset
//   cX_req / cX_gnt          request / registered grant, X in {0,1}
//   cX_cmd, cX_cmd_hasAny    command stream from requester X
//   cX_cmd_consume           core accepted the command (gated by gnt)
//   cX_in, cX_in_isReady     input stream from requester X
//   cX_in_canReceive         core can accept input (gated by gnt)
//   cX_out                   core_out, broadcast to both requesters
//   cX_out_isReady           core output valid (gated by gnt)
//   cX_out_canReceive        requester X can take the output word
//   core_*                   core-side streams; driven from the granted
//                            requester, otherwise 0
//   timeout                  one-cycle pulse when the watchdog revokes a grant

// Per-requester handshake gating and fire detection.
module main_core_arbiter_port (
  input  logic gnt,
  input  logic cmd_hasAny,
  input  logic in_isReady,
  input  logic out_canReceive,
  input  logic core_cmd_consume,
  input  logic core_in_canReceive,
  input  logic core_out_isReady,
  output logic cmd_consume,
  output logic in_canReceive,
  output logic out_isReady,
  output logic fire
);
  assign cmd_consume   = gnt & core_cmd_consume;
  assign in_canReceive = gnt & core_in_canReceive;
  assign out_isReady   = gnt & core_out_isReady;
  // Any completed handshake of the owning requester counts as progress.
  assign fire = (cmd_hasAny & cmd_consume) | (in_isReady & in_canReceive) |
                (out_canReceive & out_isReady);
endmodule

module main_core_arbiter #(
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              c0_req,
  output logic              c0_gnt,
  input  logic [CMD_W-1:0]  c0_cmd,
  input  logic              c0_cmd_hasAny,
  output logic              c0_cmd_consume,
  input  logic [DATA_W-1:0] c0_in,
  input  logic              c0_in_isReady,
  output logic              c0_in_canReceive,
  output logic [DATA_W-1:0] c0_out,
  output logic              c0_out_isReady,
  input  logic              c0_out_canReceive,
  // requester 1
  input  logic              c1_req,
  output logic              c1_gnt,
  input  logic [CMD_W-1:0]  c1_cmd,
  input  logic              c1_cmd_hasAny,
  output logic              c1_cmd_consume,
  input  logic [DATA_W-1:0] c1_in,
  input  logic              c1_in_isReady,
  output logic              c1_in_canReceive,
  output logic [DATA_W-1:0] c1_out,
  output logic              c1_out_isReady,
  input  logic              c1_out_canReceive,
  // core
  output logic [CMD_W-1:0]  core_cmd,
  output logic              core_cmd_hasAny,
  input  logic              core_cmd_consume,
  output logic [DATA_W-1:0] core_in,
  output logic              core_in_isReady,
  input  logic              core_in_canReceive,
  input  logic [DATA_W-1:0] core_out,
  input  logic              core_out_isReady,
  output logic              core_out_canReceive,
  output logic              timeout
);
  localparam int NREQ = 2;
  localparam bit WD_EN = (TIMEOUT > 0);
  // A zero-width counter is illegal, so a disabled watchdog keeps one dead bit.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

  state_t state, nxt;
  logic   last;                    // last requester that held the core
  logic [WDW-1:0] wdog;
  logic   expire;

  logic [NREQ-1:0] req, blk, elig, gnt, fire;
  logic [NREQ-1:0] has_any, in_rdy, out_crcv;
  logic [NREQ-1:0] cmd_consume, in_canReceive, out_isReady;
  logic [NREQ-1:0][CMD_W-1:0]  cmd;
  logic [NREQ-1:0][DATA_W-1:0] din;

  assign req      = {c1_req, c0_req};
  assign has_any  = {c1_cmd_hasAny, c0_cmd_hasAny};
  assign in_rdy   = {c1_in_isReady, c0_in_isReady};
  assign out_crcv = {c1_out_canReceive, c0_out_canReceive};
  assign cmd      = {c1_cmd, c0_cmd};
  assign din      = {c1_in, c0_in};
  assign elig     = req & ~blk;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_port
      main_core_arbiter_port u_port (
        .gnt               (gnt[i]),
        .cmd_hasAny        (has_any[i]),
        .in_isReady        (in_rdy[i]),
        .out_canReceive    (out_crcv[i]),
        .core_cmd_consume  (core_cmd_consume),
        .core_in_canReceive(core_in_canReceive),
        .core_out_isReady  (core_out_isReady),
        .cmd_consume       (cmd_consume[i]),
        .in_canReceive     (in_canReceive[i]),
        .out_isReady       (out_isReady[i]),
        .fire              (fire[i])
      );
    end
  endgenerate

  // Watchdog fires only on a cycle with no progress at all.
  assign expire = WD_EN && (|gnt) && !(|fire) && (wdog == WD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      // last==1 means c1 went last, so c0 wins a tie.
      IDLE: begin
        if (elig[0] && (!elig[1] || last)) nxt = GRANT0;
        else if (elig[1])                  nxt = GRANT1;
      end
      GRANT0:  if (!req[0] || expire) nxt = DRAIN;
      GRANT1:  if (!req[1] || expire) nxt = DRAIN;
      default: nxt = IDLE;
    endcase
  end

  // Outputs: grant decode and gnt-gated passthrough to the core.
  always_comb begin
    gnt                 = {state == GRANT1, state == GRANT0};
    core_cmd            = '0;
    core_cmd_hasAny     = 1'b0;
    core_in             = '0;
    core_in_isReady     = 1'b0;
    core_out_canReceive = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        core_cmd            = cmd[i];
        core_cmd_hasAny     = has_any[i];
        core_in             = din[i];
        core_in_isReady     = in_rdy[i];
        core_out_canReceive = out_crcv[i];
      end
    end
  end

  // Round-robin pointer, watchdog, block flags, timeout pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last    <= 1'b1;
      wdog    <= '0;
      blk     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (state == GRANT0 && nxt == DRAIN)      last <= 1'b0;
      else if (state == GRANT1 && nxt == DRAIN) last <= 1'b1;
      // Cleared on a fresh grant or any progress; saturates so it never wraps.
      if (!WD_EN || (state == IDLE && nxt != IDLE) || (|fire)) wdog <= '0;
      else if (wdog != WD_MAX)                                 wdog <= wdog + 1'b1;
      // Dropping req always unblocks, even if it coincides with expiry.
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i])                blk[i] <= 1'b0;
        else if (expire && gnt[i])  blk[i] <= 1'b1;
      end
    end
  end

  assign c0_gnt           = gnt[0];
  assign c1_gnt           = gnt[1];
  assign c0_cmd_consume   = cmd_consume[0];
  assign c1_cmd_consume   = cmd_consume[1];
  assign c0_in_canReceive = in_canReceive[0];
  assign c1_in_canReceive = in_canReceive[1];
  assign c0_out_isReady   = out_isReady[0];
  assign c1_out_isReady   = out_isReady[1];
  assign c0_out           = core_out;
  assign c1_out           = core_out;

endmodule
